// File: rtl/mio_arbiter_pkg.sv
// Shared definitions for the CPU/device shared-RAM arbiter: state encoding,
// widths, requester ids and the latched transaction payload.
package mio_arbiter_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ST_W            = 3;
  localparam int unsigned CNT_W           = 3;
  localparam int unsigned MEM_LAT_DEFAULT = 1;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd3;

  // Requester id; also the bit index into the arbiter request vector.
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DEV = 1'b1;

  typedef struct packed {
    logic              owner;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mio_txn_t;

endpackage

// File: rtl/mio_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = last;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = last;
    endcase
  end

endmodule

// File: rtl/mio_arbiter.sv
// Arbitrates a CPU (read/write) and a display/scan device (read-only) onto a
// single shared RAM with fixed read latency MEM_LAT; one transaction at a time.
module mio_arbiter
  import mio_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dev_req,
  input  logic [DATA_W-1:0] dev_addr,
  output logic              dev_ready,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ST_W-1:0]   state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  logic [ST_W-1:0]   state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  mio_txn_t          txn_q, txn_nxt;
  logic              last_q, last_nxt;
  logic              grant;
  logic              lat_done;
  logic              rd_capture;
  logic              mem_en_nxt, mem_we_nxt;
  logic              cpu_ready_nxt, dev_ready_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt, dev_rdata_nxt;

  rr_arb2 u_rr_arb2 (
    .req   ({dev_req, cpu_req}),
    .last  (last_q),
    .grant (grant)
  );

  // RAM address/data come straight from the latched transaction flops.
  assign mem_addr  = txn_q.addr;
  assign mem_wdata = txn_q.wdata;

  // Next state, transaction latch and registered-output next values.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt_q;
    txn_nxt       = txn_q;
    last_nxt      = last_q;
    lat_done      = (cnt_q == CNT_LAST);
    rd_capture    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_req || dev_req) begin
          state_nxt     = ST_ISSUE;
          last_nxt      = grant;
          txn_nxt.owner = grant;
          if (grant == OWNER_CPU) begin
            txn_nxt.we    = cpu_we;
            txn_nxt.addr  = cpu_addr;
            txn_nxt.wdata = cpu_wdata;
          end else begin
            txn_nxt.we    = 1'b0;
            txn_nxt.addr  = dev_addr;
            txn_nxt.wdata = '0;
          end
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (lat_done) begin
          state_nxt  = ST_DONE;
          cnt_nxt    = '0;
          rd_capture = ~txn_q.we;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    mem_en_nxt    = (state_nxt == ST_ISSUE);
    mem_we_nxt    = mem_en_nxt && txn_nxt.we && (txn_nxt.owner == OWNER_CPU);
    cpu_ready_nxt = (state_nxt == ST_DONE) && (txn_q.owner == OWNER_CPU);
    dev_ready_nxt = (state_nxt == ST_DONE) && (txn_q.owner == OWNER_DEV);
    cpu_rdata_nxt = (rd_capture && (txn_q.owner == OWNER_CPU)) ? mem_rdata : cpu_rdata;
    dev_rdata_nxt = (rd_capture && (txn_q.owner == OWNER_DEV)) ? mem_rdata : dev_rdata;
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt_q     <= '0;
      txn_q     <= '0;
      last_q    <= OWNER_DEV;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      cpu_ready <= 1'b0;
      dev_ready <= 1'b0;
      cpu_rdata <= '0;
      dev_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt_q     <= cnt_nxt;
      txn_q     <= txn_nxt;
      last_q    <= last_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      cpu_ready <= cpu_ready_nxt;
      dev_ready <= dev_ready_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      dev_rdata <= dev_rdata_nxt;
    end
  end

endmodule
